// File: rtl/icache_op_arbiter.sv
// rtl/icache_op_arbiter.sv - shares the I$ request port between fetch and CACHE maintenance ops.
// Optional OP_WAIT watchdog enabled by ICACHE_OP_TIMEOUT_EN.
module icache_op_arbiter #(
   parameter int unsigned FETCH_GRACE = 4,
   parameter int unsigned OP_TIMEOUT  = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_read,
   input  logic [31:0] fetch_vaddr,
   input  logic        fetch_flush_s1,
   input  logic        fetch_flush_s2,
   output logic        fetch_stall,
   input  logic        cop_valid,
   input  logic [2:0]  cop_type,
   input  logic [31:0] cop_vaddr,
   output logic        cop_ready,
   output logic        cop_done,
   output logic        op_timeout,
   output logic        ic_read,
   output logic [31:0] ic_vaddr,
   output logic        ic_flush_s1,
   output logic        ic_flush_s2,
   output logic        ic_op_valid,
   output logic [2:0]  ic_op_type,
   output logic [31:0] ic_op_vaddr,
   input  logic        ic_stall,
   input  logic        ic_op_done
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_OP_ISSUE,
      S_OP_WAIT,
      S_RESUME
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  grace_q, grace_d;
   logic [2:0]  op_type_q, op_type_d;
   logic [31:0] op_vaddr_q, op_vaddr_d;
`ifdef ICACHE_OP_TIMEOUT_EN
   logic [8:0]  wdog_q, wdog_d;
`endif

   assign ic_flush_s1 = fetch_flush_s1;
   assign ic_flush_s2 = fetch_flush_s2;
   assign ic_op_type  = op_type_q;
   assign ic_op_vaddr = op_vaddr_q;
   assign ic_vaddr    = fetch_vaddr;

   always_comb begin
      state_d     = state_q;
      grace_d     = grace_q;
      op_type_d   = op_type_q;
      op_vaddr_d  = op_vaddr_q;
`ifdef ICACHE_OP_TIMEOUT_EN
      wdog_d      = wdog_q;
`endif
      ic_read     = 1'b0;
      fetch_stall = 1'b1;
      cop_ready   = 1'b0;
      cop_done    = 1'b0;
      op_timeout  = 1'b0;
      ic_op_valid = 1'b0;

      case (state_q)
         S_FETCH: begin
            ic_read     = fetch_read;
            fetch_stall = ic_stall;
            if (!ic_stall && grace_q != 4'd0)
               grace_d = grace_q - 4'd1;
            // A flush in flight owns this cycle; the op waits one more.
            if (cop_valid && !ic_stall && grace_q == 4'd0 && !fetch_flush_s2) begin
               cop_ready   = 1'b1;
               op_type_d   = cop_type;
               op_vaddr_d  = cop_vaddr;
               ic_read     = 1'b0;
               fetch_stall = 1'b1;
               state_d     = S_OP_ISSUE;
            end
         end
         S_OP_ISSUE: begin
            ic_op_valid = 1'b1;
`ifdef ICACHE_OP_TIMEOUT_EN
            wdog_d      = 9'd0;
`endif
            state_d     = S_OP_WAIT;
         end
         S_OP_WAIT: begin
            if (ic_op_done) begin
               cop_done = 1'b1;
               state_d  = S_RESUME;
            end
`ifdef ICACHE_OP_TIMEOUT_EN
            else if (wdog_q == 9'(OP_TIMEOUT)) begin
               cop_done   = 1'b1;
               op_timeout = 1'b1;
               state_d    = S_RESUME;
            end else begin
               wdog_d = wdog_q + 9'd1;
            end
`endif
         end
         S_RESUME: begin
            // Re-issue the fetch that was held while the op owned the port.
            ic_read = 1'b1;
            grace_d = 4'(FETCH_GRACE);
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (rst) begin
         cop_ready   = 1'b0;
         cop_done    = 1'b0;
         op_timeout  = 1'b0;
         ic_op_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         grace_q    <= 4'd0;
         op_type_q  <= 3'd0;
         op_vaddr_q <= 32'd0;
`ifdef ICACHE_OP_TIMEOUT_EN
         wdog_q     <= 9'd0;
`endif
      end else begin
         state_q    <= state_d;
         grace_q    <= grace_d;
         op_type_q  <= op_type_d;
         op_vaddr_q <= op_vaddr_d;
`ifdef ICACHE_OP_TIMEOUT_EN
         wdog_q     <= wdog_d;
`endif
      end
   end

endmodule

// File: tb/tb_icache_op_arbiter.sv
// tb/tb_icache_op_arbiter.sv - directed self-checking bench for icache_op_arbiter.
module tb_icache_op_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_read;
   logic [31:0] fetch_vaddr;
   logic        fetch_flush_s1, fetch_flush_s2;
   logic        fetch_stall;
   logic        cop_valid;
   logic [2:0]  cop_type;
   logic [31:0] cop_vaddr;
   logic        cop_ready, cop_done, op_timeout;
   logic        ic_read;
   logic [31:0] ic_vaddr;
   logic        ic_flush_s1, ic_flush_s2;
   logic        ic_op_valid;
   logic [2:0]  ic_op_type;
   logic [31:0] ic_op_vaddr;
   logic        ic_stall;
   logic        ic_op_done;

   int checks = 0;
   int errors = 0;
   logic [34:0] exp_q[$];

   always #5 clk = ~clk;

   icache_op_arbiter #(.FETCH_GRACE(4), .OP_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .fetch_read(fetch_read), .fetch_vaddr(fetch_vaddr),
      .fetch_flush_s1(fetch_flush_s1), .fetch_flush_s2(fetch_flush_s2),
      .fetch_stall(fetch_stall),
      .cop_valid(cop_valid), .cop_type(cop_type), .cop_vaddr(cop_vaddr),
      .cop_ready(cop_ready), .cop_done(cop_done), .op_timeout(op_timeout),
      .ic_read(ic_read), .ic_vaddr(ic_vaddr),
      .ic_flush_s1(ic_flush_s1), .ic_flush_s2(ic_flush_s2),
      .ic_op_valid(ic_op_valid), .ic_op_type(ic_op_type), .ic_op_vaddr(ic_op_vaddr),
      .ic_stall(ic_stall), .ic_op_done(ic_op_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Scoreboard: every issued op must match the oldest accepted op.
   always @(negedge clk) begin
      if (!rst && ic_op_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_issue", 32'd1, 32'd0);
         end else begin
            logic [34:0] e;
            e = exp_q.pop_front();
            chk("sb_op_type", {29'd0, ic_op_type}, {29'd0, e[34:32]});
            chk("sb_op_vaddr", ic_op_vaddr, e[31:0]);
         end
      end
   end

   // Starts in the takeover cycle; returns just after the edge into FETCH (T+4).
   task automatic op_seq(input logic [2:0] t, input logic [31:0] a, input int waits, input bit keep);
      cop_valid = 1'b1;
      cop_type  = t;
      cop_vaddr = a;
      exp_q.push_back({t, a});
      settle();
      chk("take_ready", {31'd0, cop_ready}, 32'd1);
      chk("take_stall", {31'd0, fetch_stall}, 32'd1);
      chk("take_ic_read", {31'd0, ic_read}, 32'd0);
      tick();
      if (!keep) cop_valid = 1'b0;
      settle();
      chk("issue_valid", {31'd0, ic_op_valid}, 32'd1);
      chk("issue_ready", {31'd0, cop_ready}, 32'd0);
      chk("issue_ic_read", {31'd0, ic_read}, 32'd0);
      for (int i = 0; i < waits; i++) begin
         tick();
         settle();
         chk("wait_done", {31'd0, cop_done}, 32'd0);
         chk("wait_stall", {31'd0, fetch_stall}, 32'd1);
      end
      tick();
      ic_op_done = 1'b1;
      settle();
      chk("done_pulse", {31'd0, cop_done}, 32'd1);
      chk("done_timeout", {31'd0, op_timeout}, 32'd0);
      tick();
      ic_op_done = 1'b0;
      settle();
      chk("resume_ic_read", {31'd0, ic_read}, 32'd1);
      chk("resume_vaddr", ic_vaddr, fetch_vaddr);
      chk("resume_stall", {31'd0, fetch_stall}, 32'd1);
      chk("resume_done", {31'd0, cop_done}, 32'd0);
      tick();
   endtask

   task automatic idle_grace(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         chk("grace_no_ready", {31'd0, cop_ready}, 32'd0);
         chk("grace_stall", {31'd0, fetch_stall}, 32'd0);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; fetch_read = 1'b1; fetch_vaddr = 32'h0000_1000;
      fetch_flush_s1 = 1'b0; fetch_flush_s2 = 1'b0;
      cop_valid = 1'b0; cop_type = 3'd0; cop_vaddr = 32'd0;
      ic_stall = 1'b0; ic_op_done = 1'b0;
      tick();
      cop_valid = 1'b1;
      settle();
      chk("rst_ready", {31'd0, cop_ready}, 32'd0);
      chk("rst_done", {31'd0, cop_done}, 32'd0);
      chk("rst_op_valid", {31'd0, ic_op_valid}, 32'd0);
      chk("rst_timeout", {31'd0, op_timeout}, 32'd0);
      tick();
      rst = 1'b0;

      // Reset then op, minimal latency.
      op_seq(3'd0, 32'h8000_0100, 0, 1'b0);
      settle();
      chk("t4_stall_low", {31'd0, fetch_stall}, 32'd0);
      chk("t4_ic_read", {31'd0, ic_read}, 32'd1);

      // Back-to-back with cop_valid held: takeover at T+4+FETCH_GRACE.
      cop_valid = 1'b1; cop_type = 3'd3; cop_vaddr = 32'h8000_0200;
      idle_grace(4);
      op_seq(3'd3, 32'h8000_0200, 1, 1'b1);
      idle_grace(4);
      op_seq(3'd3, 32'h8000_0200, 0, 1'b0);

      // Stray ic_op_done in FETCH is ignored; then a refill blocks takeover.
      ic_op_done = 1'b1;
      settle();
      chk("stray_done", {31'd0, cop_done}, 32'd0);
      tick();
      ic_op_done = 1'b0;
      idle_grace(3);
      cop_valid = 1'b1; cop_type = 3'd5; cop_vaddr = 32'h8000_0300;
      ic_stall = 1'b1; fetch_read = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("refill_no_ready", {31'd0, cop_ready}, 32'd0);
         chk("refill_stall", {31'd0, fetch_stall}, 32'd1);
         chk("refill_ic_read", {31'd0, ic_read}, 32'd0);
         tick();
      end
      ic_stall = 1'b0; fetch_read = 1'b1;
      op_seq(3'd5, 32'h8000_0300, 2, 1'b0);

      // Flush in FETCH blocks takeover for one cycle, flush in OP_WAIT does not abort.
      idle_grace(4);
      cop_valid = 1'b1; cop_type = 3'd1; cop_vaddr = 32'h8000_0400;
      fetch_flush_s1 = 1'b1; fetch_flush_s2 = 1'b1;
      settle();
      chk("flush_blocks_ready", {31'd0, cop_ready}, 32'd0);
      chk("flush_s1_pass", {31'd0, ic_flush_s1}, 32'd1);
      chk("flush_s2_pass", {31'd0, ic_flush_s2}, 32'd1);
      tick();
      fetch_flush_s1 = 1'b0; fetch_flush_s2 = 1'b0;
      exp_q.push_back({3'd1, 32'h8000_0400});
      settle();
      chk("flush_next_ready", {31'd0, cop_ready}, 32'd1);
      tick();
      cop_valid = 1'b0;
      settle();
      chk("flush_issue", {31'd0, ic_op_valid}, 32'd1);
      tick();
      fetch_flush_s2 = 1'b1;
      settle();
      chk("wait_flush_s2", {31'd0, ic_flush_s2}, 32'd1);
      chk("wait_flush_done", {31'd0, cop_done}, 32'd0);
      tick();
      ic_op_done = 1'b1; fetch_vaddr = 32'h0000_2000;
      settle();
      chk("flush_op_done", {31'd0, cop_done}, 32'd1);
      tick();
      ic_op_done = 1'b0; fetch_flush_s2 = 1'b0;
      settle();
      chk("flush_resume_read", {31'd0, ic_read}, 32'd1);
      chk("flush_resume_vaddr", ic_vaddr, 32'h0000_2000);
      tick();

      // Reset during OP_WAIT drops the op without cop_done.
      idle_grace(4);
      cop_valid = 1'b1; cop_type = 3'd2; cop_vaddr = 32'h8000_0500;
      exp_q.push_back({3'd2, 32'h8000_0500});
      settle();
      chk("rstop_ready", {31'd0, cop_ready}, 32'd1);
      tick();
      cop_valid = 1'b0;
      settle();
      chk("rstop_issue", {31'd0, ic_op_valid}, 32'd1);
      tick();
      rst = 1'b1;
      settle();
      chk("rstop_no_done", {31'd0, cop_done}, 32'd0);
      tick();
      rst = 1'b0; ic_op_done = 1'b1;
      settle();
      chk("rstop_fetch_stall", {31'd0, fetch_stall}, 32'd0);
      chk("rstop_late_done", {31'd0, cop_done}, 32'd0);
      chk("rstop_op_valid", {31'd0, ic_op_valid}, 32'd0);
      tick();
      ic_op_done = 1'b0;
      op_seq(3'd6, 32'h8000_0600, 0, 1'b0);

`ifdef ICACHE_OP_TIMEOUT_EN
      idle_grace(4);
      cop_valid = 1'b1; cop_type = 3'd7; cop_vaddr = 32'h8000_0700;
      exp_q.push_back({3'd7, 32'h8000_0700});
      settle();
      chk("wd_ready", {31'd0, cop_ready}, 32'd1);
      tick();
      cop_valid = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         settle();
         chk("wd_no_timeout", {31'd0, op_timeout}, 32'd0);
         chk("wd_no_done", {31'd0, cop_done}, 32'd0);
         tick();
      end
      settle();
      chk("wd_timeout", {31'd0, op_timeout}, 32'd1);
      chk("wd_done", {31'd0, cop_done}, 32'd1);
      tick();
      settle();
      chk("wd_resume_read", {31'd0, ic_read}, 32'd1);
      chk("wd_resume_timeout", {31'd0, op_timeout}, 32'd0);
      tick();
`endif

      settle();
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/icache_op_arbiter.md
# icache_op_arbiter

Shares the single instruction-cache request port between the fetch unit and cache-maintenance operations (MIPS `CACHE` ops on the I-side) issued from the execute stage. It sits between the fetch stage and the I$. It sequences each maintenance op as takeover → issue → wait → resume, stalling fetch for the whole sequence. A grace counter guarantees fetch forward progress between back-to-back ops.

## Interface
Parameters:
- `FETCH_GRACE`, default 4: minimum number of unstalled FETCH-state cycles after an op completes before the next op may be accepted (range 0–15).
- `OP_TIMEOUT`, default 256: OP_WAIT watchdog limit in cycles; used only with the timeout feature.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `fetch_read` in 1: fetch read request.
- `fetch_vaddr` in 32: fetch address, already aligned.
- `fetch_flush_s1`, `fetch_flush_s2` in 1: fetch flush requests.
- `fetch_stall` out 1: stall to fetch; fetch treats it exactly as an I$ stall.
- `cop_valid` in 1: maintenance op pending.
- `cop_type` in 3: op code.
- `cop_vaddr` in 32: op address.
- `cop_ready` out 1: 1-cycle accept pulse.
- `cop_done` out 1: 1-cycle completion pulse.
- `op_timeout` out 1: 1-cycle watchdog-abort pulse.
- `ic_read` out 1, `ic_vaddr` out 32: I$ read port.
- `ic_flush_s1`, `ic_flush_s2` out 1: I$ flush signals.
- `ic_op_valid` out 1, `ic_op_type` out 3, `ic_op_vaddr` out 32: I$ op port.
- `ic_stall` in 1: I$ busy (miss or refill).
- `ic_op_done` in 1: I$ op finished.

## Operation
- FSM states: FETCH, OP_ISSUE, OP_WAIT, RESUME. Reset state is FETCH.
- **FETCH**
  - Pass-through: `ic_read`=`fetch_read`, `ic_vaddr`=`fetch_vaddr`, `fetch_stall`=`ic_stall`.
  - Takeover condition: `cop_valid` & ~`ic_stall` & (grace_cnt == 0) & ~`fetch_flush_s2`.
  - On takeover:
    - `cop_ready`=1.
    - Latch `cop_type` and `cop_vaddr` into the op registers.
    - `ic_read`=0 and `fetch_stall`=1 in that same cycle.
    - Next state is OP_ISSUE.
- **OP_ISSUE**
  - `ic_op_valid`=1 for exactly one cycle, carrying the latched type and address.
  - `ic_read`=0, `fetch_stall`=1.
  - Next state is OP_WAIT.
- **OP_WAIT**
  - `ic_read`=0, `fetch_stall`=1.
  - On `ic_op_done`: `cop_done`=1 that cycle; next state is RESUME.
- **RESUME**
  - `ic_read`=1, `ic_vaddr`=`fetch_vaddr` (fetch holds its address while stalled), `fetch_stall`=1.
  - Load grace_cnt with `FETCH_GRACE`.
  - Next state is FETCH.
- **Grace counter** (4 bits): decrements by 1 in each FETCH cycle with ~`ic_stall`; saturates at 0. Reset value is 0, so an op is accepted immediately after reset.
- **Flushes**
  - `ic_flush_s1`/`ic_flush_s2` equal `fetch_flush_s1`/`fetch_flush_s2` in every state, combinationally.
  - A flush never aborts an accepted op and does not change FSM state.
  - A flush in FETCH blocks takeover for that cycle only.
- `cop_valid` with an op already accepted: it is not acknowledged again until the FSM returns to FETCH and the grace counter reaches 0.
- Reset values, with `rst` taking effect mid-sequence: state=FETCH, grace_cnt=0, op registers=0, watchdog=0.
  - `cop_ready`, `cop_done`, `op_timeout` and `ic_op_valid` are all 0 in the cycle following reset.
  - An in-flight op is dropped without `cop_done`.

## Timing
- Minimum op sequence: takeover (T) → OP_ISSUE (T+1) → OP_WAIT (T+2, with `ic_op_done` at T+2) → RESUME (T+3) → FETCH (T+4). That is 4 stalled fetch cycles.
- `cop_ready` is registered-state-decoded but combinational on the inputs; `cop_done` is combinational from `ic_op_done` in OP_WAIT.
- `ic_op_done` asserted in any state other than OP_WAIT is ignored.
- Next possible takeover after RESUME: FETCH cycle T+4+`FETCH_GRACE` (FETCH_GRACE=0 gives T+4).

## Configuration
- Macro `ICACHE_OP_TIMEOUT_EN`.
- **Defined:** a 9-bit watchdog clears on entry to OP_WAIT and increments each OP_WAIT cycle. If it reaches `OP_TIMEOUT` without `ic_op_done`:
  - `op_timeout`=1 and `cop_done`=1 for one cycle;
  - next state is RESUME.
- **Undefined:** no watchdog logic; `op_timeout` is tied to 0 and OP_WAIT waits indefinitely.

## Test plan
- **Reset then op:** reset, then `cop_valid`=1 with `cop_vaddr`=0x8000_0100, type=0, and `ic_op_done` on its first OP_WAIT cycle. Required: `cop_ready` in cycle 0, `ic_op_valid` in cycle 1, `cop_done` in cycle 2, `ic_read`=1 with `ic_vaddr`=`fetch_vaddr` in cycle 3, `fetch_stall` low in cycle 4.
- **Back-to-back ops, FETCH_GRACE=4:** `cop_valid` held high. Required: the second `cop_ready` appears exactly 4 unstalled FETCH cycles after RESUME.
- **Refill blocks takeover:** `ic_stall`=1 for 10 cycles with `cop_valid`=1. Required: no `cop_ready` while stalled; takeover in the first cycle with `ic_stall`=0.
- **Flush during OP_WAIT:** assert `fetch_flush_s2`. Required: `ic_flush_s2` passes through, the op still completes with `cop_done`, and RESUME issues the new `fetch_vaddr`.
- **Reset mid-op:** `rst` in OP_WAIT. Required: state FETCH next cycle, `cop_done` never pulses, grace_cnt=0.
- **Watchdog (`ICACHE_OP_TIMEOUT_EN`, OP_TIMEOUT=16):** `ic_op_done` never asserted. Required: `op_timeout` and `cop_done` pulse together after 16 OP_WAIT cycles, then RESUME.
